mips_regfile_sb: RTL and testbench
==================================

MIPS_REGFILE_SB -- requirements
Module: mips_regfile_sb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 16, register data width.
- NUM_REGS, 8, register count; AW = $clog2(NUM_REGS).
- NUM_RD, 2, read port count.
- MAX_PEND, 3, maximum outstanding writes tracked per register.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on rising edge.
- rst, in, 1, reset, asynchronous, active-low.
- reg_read_addr, in, NUM_RD x AW, decode source addresses.
- rd_check_en, in, NUM_RD, per-port: source is used and must be hazard-checked.
- reg_read_data, out, NUM_RD x DATA_W, read data.
- issue_valid, in, 1, decode issues an instruction that writes a register.
- issue_dest, in, AW, destination of the issued instruction.
- reg_write_en, in, 1, writeback enable.
- reg_write_dest, in, AW, writeback address.
- reg_write_data, in, DATA_W, writeback data.
- flush, in, 1, clear all pending-write tracking.
- pipeline_stall_n, out, 1, 0 = hold decode.
- pending_any, out, 1, any register has a nonzero pending count.

Function
REQ-003 R0 SHALL always read 0; writes, issues and retires to R0 are ignored.
REQ-004 A write SHALL update the register on the rising edge when reg_write_en = 1.
REQ-005 Reads SHALL be combinational from the register array, subject to REQ-013.
REQ-006 Each register SHALL have a pending counter of width $clog2(MAX_PEND+1), reset to 0.
REQ-007 Issue SHALL be accepted only when issue_valid = 1 and pipeline_stall_n = 1; acceptance increments pend[issue_dest].
REQ-008 Retire: reg_write_en = 1 SHALL decrement pend[reg_write_dest]; a count of 0 stays 0 (no underflow).
REQ-009 An accepted issue and a retire to the same register in the same cycle SHALL leave the count unchanged.
REQ-010 pipeline_stall_n SHALL be 0 when either condition holds:
- any port i with rd_check_en[i] = 1 has an effective pending count for reg_read_addr[i] that is nonzero;
- issue_valid = 1 and pend[issue_dest] = MAX_PEND (saturation).
The output is combinational, zero-cycle latency.
REQ-011 flush SHALL zero all counters on the next edge, overriding a same-cycle issue and retire; later writes still update data.
REQ-012 pending_any SHALL be the registered OR of all counters.

Reset
REQ-014 While rst = 0, all registers and counters SHALL be 0, pipeline_stall_n = 1 and pending_any = 0, asynchronously.
REQ-015 Reset asserted mid-operation SHALL discard all pending state; the first edge after release behaves as from power-up.

Configuration
REQ-013 With macro REGFILE_BYPASS_EN defined:
- reading the address being written in the same cycle SHALL return reg_write_data;
- the effective pending count for REQ-010 is the count minus one when that register retires this cycle.
Without the macro, reads SHALL return the stored value and the raw count is used.

Structure
REQ-016 A shared package SHALL hold the default parameter values and a typedef for the pending-counter type; mips_16_defs.v widths are reused.
REQ-017 The scoreboard counter array SHALL be the sub-module mips_pend_scoreboard. The data array stays in the top.

Verification
REQ-018 The bench SHALL cover these directed scenarios (NUM_REGS = 8, DATA_W = 16, MAX_PEND = 3):
- Reset: rst = 0 mid-run with pend[R3] = 2 -> stall_n = 1, all reads 0, pending_any = 0.
- RAW stall: issue R2; next cycle read R2 with check enabled -> stall_n = 0 until writeback of 0x00A5; with BYPASS_EN, stall_n = 1 in the writeback cycle and data = 0x00A5; without it, stall_n = 1 one cycle later.
- Saturation: three issues to R5 -> fourth issue_valid to R5 gives stall_n = 0; one retire -> stall_n = 1.
- Simultaneous issue and retire on R4 at count 1 -> count stays 1.
- R0: write 0xFFFF to R0 -> reads 0, no stall.
- flush with pend[R1] = 2 -> stall clears next cycle; a later retire to R1 keeps the count at 0.

Source files
------------

// File: rtl/mips_regfile_sb_pkg.sv
// Shared defaults for the register file / scoreboard slice; widths follow mips_16_defs.v.
package mips_regfile_sb_pkg;
  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 8;
  localparam int NUM_RD_DEF   = 2;
  localparam int MAX_PEND_DEF = 3;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);
  localparam int PEND_W_DEF   = $clog2(MAX_PEND_DEF + 1);

  typedef logic [PEND_W_DEF-1:0] pend_t;
endpackage

// File: rtl/mips_regfile_sb_if.sv
// Decode/writeback bus of the register file: read ports, issue, writeback, stall.
interface mips_regfile_sb_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD-1:0][AW-1:0]     reg_read_addr;
  logic [NUM_RD-1:0]             rd_check_en;
  logic [NUM_RD-1:0][DATA_W-1:0] reg_read_data;
  logic                          issue_valid;
  logic [AW-1:0]                 issue_dest;
  logic                          reg_write_en;
  logic [AW-1:0]                 reg_write_dest;
  logic [DATA_W-1:0]             reg_write_data;
  logic                          flush;
  logic                          pipeline_stall_n;
  logic                          pending_any;

  modport master (
    output reg_read_addr, rd_check_en, issue_valid, issue_dest,
           reg_write_en, reg_write_dest, reg_write_data, flush,
    input  reg_read_data, pipeline_stall_n, pending_any
  );

  modport slave (
    input  reg_read_addr, rd_check_en, issue_valid, issue_dest,
           reg_write_en, reg_write_dest, reg_write_data, flush,
    output reg_read_data, pipeline_stall_n, pending_any
  );
endinterface

// File: rtl/mips_regfile_sb_pend.sv
// Per-register outstanding-write counters; pending_any is registered alongside them.
module mips_pend_scoreboard
  import mips_regfile_sb_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_acc,
  input  logic [AW-1:0]                issue_dest,
  input  logic                         retire,
  input  logic [AW-1:0]                retire_dest,
  input  logic                         flush,
  output logic [NUM_REGS-1:0][PW-1:0]  pend,
  output logic                         pending_any
);
  logic [NUM_REGS-1:0][PW-1:0] pend_nxt;
  logic                        any_nxt;

  always_comb begin
    pend_nxt = pend;
    any_nxt  = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (flush) begin
        pend_nxt[r] = '0;
      end else if (issue_acc && issue_dest == AW'(r)) begin
        // A matching retire in the same cycle cancels the increment.
        if (!(retire && retire_dest == AW'(r)) && pend[r] != PW'(MAX_PEND))
          pend_nxt[r] = pend[r] + PW'(1);
      end else if (retire && retire_dest == AW'(r) && pend[r] != '0) begin
        pend_nxt[r] = pend[r] - PW'(1);
      end
      any_nxt = any_nxt | (pend_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend        <= '0;
      pending_any <= 1'b0;
    end else begin
      pend        <= pend_nxt;
      pending_any <= any_nxt;
    end
  end
endmodule

// File: rtl/mips_regfile_sb.sv
// Register file with write-pending scoreboard and decode stall generation.
// Optional REGFILE_BYPASS_EN forwards same-cycle writeback data and retire credit.
module mips_regfile_sb
  import mips_regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int MAX_PEND = MAX_PEND_DEF
) (
  input logic         clk,
  input logic         rst,
  mips_regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int PW = $clog2(MAX_PEND + 1);

  logic [DATA_W-1:0]           regs [NUM_REGS];
  logic [NUM_REGS-1:0][PW-1:0] pend;
  logic                        issue_acc;
  logic                        hazard;
  logic                        sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (bus.reg_write_en && bus.reg_write_dest != '0) begin
      regs[bus.reg_write_dest] <= bus.reg_write_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      bus.reg_read_data[i] = '0;
      if (bus.reg_read_addr[i] != '0) begin
        bus.reg_read_data[i] = regs[bus.reg_read_addr[i]];
`ifdef REGFILE_BYPASS_EN
        if (rst && bus.reg_write_en && bus.reg_write_dest == bus.reg_read_addr[i])
          bus.reg_read_data[i] = bus.reg_write_data;
`endif
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [PW-1:0] eff;
      eff = pend[bus.reg_read_addr[i]];
`ifdef REGFILE_BYPASS_EN
      // Retiring this cycle releases one outstanding write early.
      if (bus.reg_write_en && bus.reg_write_dest == bus.reg_read_addr[i] && eff != '0)
        eff = eff - PW'(1);
`endif
      if (bus.rd_check_en[i] && bus.reg_read_addr[i] != '0 && eff != '0)
        hazard = 1'b1;
    end
    sat = bus.issue_valid && pend[bus.issue_dest] == PW'(MAX_PEND);
    bus.pipeline_stall_n = !(hazard || sat);
  end

  assign issue_acc = bus.issue_valid && bus.pipeline_stall_n;

  mips_pend_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .MAX_PEND (MAX_PEND),
    .AW       (AW),
    .PW       (PW)
  ) u_pend (
    .clk         (clk),
    .rst         (rst),
    .issue_acc   (issue_acc),
    .issue_dest  (bus.issue_dest),
    .retire      (bus.reg_write_en),
    .retire_dest (bus.reg_write_dest),
    .flush       (bus.flush),
    .pend        (pend),
    .pending_any (bus.pending_any)
  );
endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed vector bench for mips_regfile_sb (NUM_REGS=8, DATA_W=16, MAX_PEND=3).
module tb_mips_regfile_sb;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mips_regfile_sb_if #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2)) bus ();

  mips_regfile_sb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .MAX_PEND(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [2:0]  idst;
    logic        we;
    logic [2:0]  wdst;
    logic [15:0] wdat;
    logic        fl;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [1:0]  chk;
    logic        e_stall_n;
    logic [15:0] e_rd0;
    logic [15:0] e_rd1;
    logic        e_pany;
  } vec_t;

  vec_t vecs [40];
  int   nvec;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic add(input logic iv, input logic [2:0] idst, input logic we,
                     input logic [2:0] wdst, input logic [15:0] wdat, input logic fl,
                     input logic [2:0] ra0, input logic [2:0] ra1, input logic [1:0] chk,
                     input logic es, input logic [15:0] e0, input logic [15:0] e1,
                     input logic ep);
    vecs[nvec] = '{iv, idst, we, wdst, wdat, fl, ra0, ra1, chk, es, e0, e1, ep};
    nvec++;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.issue_valid    = v.iv;
    bus.issue_dest     = v.idst;
    bus.reg_write_en   = v.we;
    bus.reg_write_dest = v.wdst;
    bus.reg_write_data = v.wdat;
    bus.flush          = v.fl;
    bus.reg_read_addr[0] = v.ra0;
    bus.reg_read_addr[1] = v.ra1;
    bus.rd_check_en    = v.chk;
  endtask

  task automatic check_outs(input string tag, input logic es, input logic [15:0] e0,
                            input logic [15:0] e1, input logic ep);
    check({tag, " stall_n"}, 16'(bus.pipeline_stall_n), 16'(es));
    check({tag, " rd0"}, bus.reg_read_data[0], e0);
    check({tag, " rd1"}, bus.reg_read_data[1], e1);
    check({tag, " pending_any"}, 16'(bus.pending_any), 16'(ep));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t idle;

  initial begin
    checks = 0;
    errors = 0;
    nvec   = 0;
    idle   = '{1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 2'b00, 1'b1, 16'h0, 16'h0, 1'b0};

    // iv idst we wdst wdat fl ra0 ra1 chk | stall_n rd0 rd1 pany
    add(0,0, 1,1,16'h1111, 0, 2,3,2'b00, 1, 16'h0000, 16'h0000, 0);
    add(0,0, 1,2,16'h2222, 0, 1,0,2'b00, 1, 16'h1111, 16'h0000, 0);
    add(0,0, 1,0,16'hFFFF, 0, 2,0,2'b11, 1, 16'h2222, 16'h0000, 0);
    add(0,0, 0,0,16'h0000, 0, 0,1,2'b11, 1, 16'h0000, 16'h1111, 0);
    // RAW on R2
    add(1,2, 0,0,16'h0000, 0, 3,4,2'b00, 1, 16'h0000, 16'h0000, 0);
    add(0,0, 0,0,16'h0000, 0, 2,1,2'b01, 0, 16'h2222, 16'h1111, 1);
    add(0,0, 0,0,16'h0000, 0, 2,1,2'b01, 0, 16'h2222, 16'h1111, 1);
    add(0,0, 1,2,16'h00A5, 0, 2,1,2'b01, BYP, BYP ? 16'h00A5 : 16'h2222, 16'h1111, 1);
    add(0,0, 0,0,16'h0000, 0, 2,1,2'b01, 1, 16'h00A5, 16'h1111, 0);
    // saturation on R5
    add(1,5, 0,0,16'h0000, 0, 1,2,2'b00, 1, 16'h1111, 16'h00A5, 0);
    add(1,5, 0,0,16'h0000, 0, 1,2,2'b00, 1, 16'h1111, 16'h00A5, 1);
    add(1,5, 0,0,16'h0000, 0, 1,2,2'b00, 1, 16'h1111, 16'h00A5, 1);
    add(1,5, 0,0,16'h0000, 0, 1,2,2'b00, 0, 16'h1111, 16'h00A5, 1);
    add(0,0, 1,5,16'h5555, 0, 1,2,2'b00, 1, 16'h1111, 16'h00A5, 1);
    add(1,5, 0,0,16'h0000, 0, 1,2,2'b00, 1, 16'h1111, 16'h00A5, 1);
    add(1,5, 0,0,16'h0000, 0, 1,2,2'b00, 0, 16'h1111, 16'h00A5, 1);
    // simultaneous issue and retire on R4 at count 1
    add(1,4, 0,0,16'h0000, 0, 1,2,2'b00, 1, 16'h1111, 16'h00A5, 1);
    add(1,4, 1,4,16'h4444, 0, 3,1,2'b00, 1, 16'h0000, 16'h1111, 1);
    add(0,0, 0,0,16'h0000, 0, 4,1,2'b01, 0, 16'h4444, 16'h1111, 1);
    add(0,0, 1,4,16'h4444, 0, 4,1,2'b00, 1, 16'h4444, 16'h1111, 1);
    add(0,0, 0,0,16'h0000, 0, 4,1,2'b01, 1, 16'h4444, 16'h1111, 1);
    // flush with pend[R1] = 2
    add(1,1, 0,0,16'h0000, 0, 3,2,2'b00, 1, 16'h0000, 16'h00A5, 1);
    add(1,1, 0,0,16'h0000, 0, 3,2,2'b00, 1, 16'h0000, 16'h00A5, 1);
    add(0,0, 0,0,16'h0000, 1, 1,2,2'b01, 0, 16'h1111, 16'h00A5, 1);
    add(0,0, 0,0,16'h0000, 0, 1,5,2'b11, 1, 16'h1111, 16'h5555, 0);
    add(0,0, 1,1,16'h1234, 0, 3,2,2'b11, 1, 16'h0000, 16'h00A5, 0);
    add(0,0, 0,0,16'h0000, 0, 1,5,2'b01, 1, 16'h1234, 16'h5555, 0);
    // flush overrides same-cycle issue and retire
    add(1,6, 0,0,16'h0000, 0, 1,5,2'b00, 1, 16'h1234, 16'h5555, 0);
    add(1,3, 1,7,16'h7777, 1, 1,5,2'b00, 1, 16'h1234, 16'h5555, 1);
    add(0,0, 0,0,16'h0000, 0, 3,6,2'b11, 1, 16'h0000, 16'h0000, 0);
    add(0,0, 0,0,16'h0000, 0, 7,0,2'b11, 1, 16'h7777, 16'h0000, 0);

    // power-up reset
    rst = 1'b0;
    drive(idle);
    #12;
    check_outs("por", 1'b1, 16'h0, 16'h0, 1'b0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i]);
      #3;
      check_outs($sformatf("vec%0d", i), vecs[i].e_stall_n, vecs[i].e_rd0,
                 vecs[i].e_rd1, vecs[i].e_pany);
      next_cycle();
    end

    // mid-run reset with pend[R3] = 2
    drive(idle);
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 3'd3;
    next_cycle();
    next_cycle();
    bus.issue_valid      = 1'b0;
    bus.reg_read_addr[0] = 3'd3;
    bus.reg_read_addr[1] = 3'd1;
    bus.rd_check_en      = 2'b01;
    #2;
    check_outs("pre_rst", 1'b0, 16'h0000, 16'h1234, 1'b1);
    rst = 1'b0;
    #1;
    check_outs("mid_rst", 1'b1, 16'h0000, 16'h0000, 1'b0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    check_outs("post_rst", 1'b1, 16'h0000, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
